// File: rtl/nap_alarm_scheduler.sv
// Drives the external BCD time adder to compute wake time = cur_time + nap_len.
// It re-launches the adder while the sum is unnormalised, wraps at 24 h, then arms and raises the alarm.
//
// state  | meaning
// IDLE   | waiting for start
// LAUNCH | add_en high for one cycle
// WAIT   | waiting for add_complete, timeout running
// CHECK  | decide: saturation, relaunch, pass overflow or wrap
// WRAP   | fold hours >= 24 back into 00..23, load alarm_time
// ARMED  | waiting for cur_time == alarm_time
// ALARM  | alarm raised until ack/cancel
module nap_alarm_scheduler #(
  parameter int MAX_PASSES   = 8,
  parameter int WAIT_TIMEOUT = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] cur_time,
  input  logic [23:0] nap_len,
  input  logic        start,
  input  logic        cancel,
  input  logic        ack,
  output logic        add_en,
  output logic [23:0] add_o,
  output logic [23:0] add_p,
  input  logic [23:0] add_result,
  input  logic        add_complete,
  input  logic        add_recursive,
  output logic [23:0] alarm_time,
  output logic        armed,
  output logic        alarm,
  output logic        busy,
  output logic        err,
  output logic [3:0]  pass_cnt
);

  localparam int TW = $clog2(WAIT_TIMEOUT);
  localparam logic [TW-1:0] T_LOAD = TW'(WAIT_TIMEOUT - 1);
  localparam logic [3:0]    MAX_P  = 4'(MAX_PASSES);
  localparam logic [23:0]   SAT    = 24'h995959;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_CHECK, S_WRAP, S_ARMED, S_ALARM
  } state_t;

  state_t         state;
  logic [TW-1:0]  timer;
  logic [23:0]    res;
  logic           rec;
  logic [23:0]    wrapped;

  // BCD subtract of 24 from the hour pair: ones digit -4 with borrow, tens digit -2.
  always_comb begin
    wrapped = res;
    if (res[23:16] >= 8'h24) begin
      if (res[19:16] < 4'd4) begin
        wrapped[19:16] = res[19:16] + 4'd6;
        wrapped[23:20] = res[23:20] - 4'd3;
      end else begin
        wrapped[19:16] = res[19:16] - 4'd4;
        wrapped[23:20] = res[23:20] - 4'd2;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      add_en     <= 1'b0;
      add_o      <= '0;
      add_p      <= '0;
      alarm_time <= '0;
      armed      <= 1'b0;
      alarm      <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      pass_cnt   <= '0;
      timer      <= '0;
      res        <= '0;
      rec        <= 1'b0;
    end else begin
      add_en <= 1'b0;
      if (cancel && state != S_IDLE) begin
        state <= S_IDLE;
        armed <= 1'b0;
        alarm <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            add_o    <= cur_time;
            add_p    <= nap_len;
            pass_cnt <= '0;
            err      <= 1'b0;
            add_en   <= 1'b1;
            busy     <= 1'b1;
            state    <= S_LAUNCH;
          end
          S_LAUNCH: begin
            pass_cnt <= pass_cnt + 4'd1;
            timer    <= T_LOAD;
            state    <= S_WAIT;
          end
          S_WAIT: begin
            if (add_complete) begin
              res   <= add_result;
              rec   <= add_recursive;
              state <= S_CHECK;
            end else if (timer == '0) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          S_CHECK: begin
            if (!rec && res == SAT) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (rec && pass_cnt < MAX_P) begin
              add_o  <= res;
              add_p  <= '0;
              add_en <= 1'b1;
              state  <= S_LAUNCH;
            end else if (rec) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              state <= S_WRAP;
            end
          end
          S_WRAP: begin
            alarm_time <= wrapped;
            armed      <= 1'b1;
            busy       <= 1'b0;
            state      <= S_ARMED;
          end
          S_ARMED: if (cur_time == alarm_time) begin
            armed <= 1'b0;
            alarm <= 1'b1;
            state <= S_ALARM;
          end
          S_ALARM: if (ack) begin
            alarm <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nap_alarm_scheduler.sv
// Directed bench for nap_alarm_scheduler; the bench plays the adder with hand-computed responses.
module tb_nap_alarm_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] cur_time, nap_len;
  logic        start, cancel, ack;
  logic        add_en;
  logic [23:0] add_o, add_p;
  logic [23:0] add_result;
  logic        add_complete, add_recursive;
  logic [23:0] alarm_time;
  logic        armed, alarm, busy, err;
  logic [3:0]  pass_cnt;

  int errors = 0;
  int checks = 0;

  nap_alarm_scheduler #(.MAX_PASSES(8), .WAIT_TIMEOUT(32)) dut (
    .clock(clock), .reset(reset), .cur_time(cur_time), .nap_len(nap_len),
    .start(start), .cancel(cancel), .ack(ack), .add_en(add_en),
    .add_o(add_o), .add_p(add_p), .add_result(add_result),
    .add_complete(add_complete), .add_recursive(add_recursive),
    .alarm_time(alarm_time), .armed(armed), .alarm(alarm), .busy(busy),
    .err(err), .pass_cnt(pass_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic kick(input logic [23:0] c, input logic [23:0] n);
    cur_time = c; nap_len = n; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (add_en !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    check({tag, "_add_en"}, 24'(add_en), 24'h1);
  endtask

  // Adder stand-in: one launch, operand check, result returned on the following cycle.
  task automatic serve(input string tag, input logic [23:0] eo, input logic [23:0] ep,
                       input logic [23:0] r, input logic rc);
    wait_en(tag);
    check({tag, "_add_o"}, add_o, eo);
    check({tag, "_add_p"}, add_p, ep);
    @(negedge clock);
    add_result = r; add_recursive = rc; add_complete = 1'b1;
    @(negedge clock);
    add_result = '0; add_recursive = 1'b0; add_complete = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen_en;
    reset = 1'b1; cur_time = '0; nap_len = '0; start = 0; cancel = 0; ack = 0;
    add_result = '0; add_complete = 0; add_recursive = 0;
    cyc(2);
    reset = 1'b0;
    @(negedge clock);
    check("rst_outputs", {add_en, armed, alarm, busy, err, pass_cnt}, 24'h0);
    check("rst_add_o", add_o, 24'h0);
    check("rst_add_p", add_p, 24'h0);
    check("rst_alarm_time", alarm_time, 24'h0);

    // 1: single pass 07:30:00 + 00:20:00
    kick(24'h073000, 24'h002000);
    check("t1_busy", 24'(busy), 24'h1);
    serve("t1", 24'h073000, 24'h002000, 24'h075000, 1'b0);
    cyc(2);
    check("t1_alarm_time", alarm_time, 24'h075000);
    check("t1_armed", 24'(armed), 24'h1);
    check("t1_pass_cnt", 24'(pass_cnt), 24'h1);
    check("t1_err_busy", {err, busy}, 24'h0);
    do_cancel();
    check("t1_cancel_armed", 24'(armed), 24'h0);

    // 2: four passes to normalise 07:45:50 + 00:14:15
    kick(24'h074550, 24'h001415);
    serve("t2p1", 24'h074550, 24'h001415, 24'h075965, 1'b1);
    serve("t2p2", 24'h075965, 24'h000000, 24'h075a05, 1'b1);
    serve("t2p3", 24'h075a05, 24'h000000, 24'h076005, 1'b1);
    serve("t2p4", 24'h076005, 24'h000000, 24'h080005, 1'b0);
    cyc(2);
    check("t2_alarm_time", alarm_time, 24'h080005);
    check("t2_pass_cnt", 24'(pass_cnt), 24'h4);
    check("t2_armed", 24'(armed), 24'h1);
    do_cancel();

    // 3: 23:30:00 + 01:00:00 wraps to 00:30:00
    kick(24'h233000, 24'h010000);
    serve("t3", 24'h233000, 24'h010000, 24'h243000, 1'b0);
    cyc(2);
    check("t3_alarm_time", alarm_time, 24'h003000);
    check("t3_armed", 24'(armed), 24'h1);
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    check("t3_ack_ignored", {armed, alarm}, 24'h2);

    // 4: wall clock reaches alarm time
    cur_time = 24'h002959;
    @(negedge clock);
    check("t4_no_match", {armed, alarm}, 24'h2);
    cur_time = 24'h003000;
    @(negedge clock);
    check("t4_alarm", {armed, alarm}, 24'h1);
    @(negedge clock);
    check("t4_alarm_held", 24'(alarm), 24'h1);
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    check("t4_ack", {armed, alarm, busy}, 24'h0);

    // 5: cancel in WAIT, late add_complete ignored
    kick(24'h010000, 24'h000500);
    wait_en("t5");
    @(negedge clock);
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    add_result = 24'h010500; add_complete = 1'b1;
    @(negedge clock);
    add_result = '0; add_complete = 1'b0;
    seen_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen_en = seen_en | add_en;
      @(negedge clock);
    end
    check("t5_add_en_quiet", 24'(seen_en), 24'h0);
    check("t5_state", {armed, alarm, busy}, 24'h0);
    check("t5_alarm_time", alarm_time, 24'h003000);
    check("t5_pass_cnt", 24'(pass_cnt), 24'h1);

    // 6: timeout exactly 32 cycles after the LAUNCH cycle
    kick(24'h120000, 24'h001000);
    wait_en("t6");
    cyc(32);
    check("t6_err_not_yet", {err, busy}, 24'h1);
    @(negedge clock);
    check("t6_err_timeout", {err, busy}, 24'h2);
    kick(24'h120000, 24'h001000);
    check("t6_start_clears_err", 24'(err), 24'h0);
    serve("t6b", 24'h120000, 24'h001000, 24'h121000, 1'b0);
    cyc(2);
    check("t6b_alarm_time", alarm_time, 24'h121000);
    do_cancel();

    // saturation result
    kick(24'h235959, 24'h235959);
    serve("sat", 24'h235959, 24'h235959, 24'h995959, 1'b0);
    @(negedge clock);
    check("sat_err", {err, busy, armed}, 24'h4);

    // pass overflow: adder never normalises
    kick(24'h010000, 24'h000000);
    serve("ovf1", 24'h010000, 24'h000000, 24'h010001, 1'b1);
    for (int i = 2; i <= 8; i++)
      serve($sformatf("ovf%0d", i), 24'h010001, 24'h000000, 24'h010001, 1'b1);
    @(negedge clock);
    check("ovf_err", {err, busy, armed}, 24'h4);
    check("ovf_pass_cnt", 24'(pass_cnt), 24'h8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
